pipe_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Merges four event sources into one per-stage hold vector, one per-stage bubble vector and a PC redirect:
  - load-use hazards from ID,
  - multi-cycle EX operations,
  - data-bus wait states from MEM,
  - taken branches from EX.
- Runs a watchdog on bus waits. On timeout it forces a full pipeline flush to a trap vector.

---
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// Merges load-use, multi-cycle EX, bus-wait and branch events into per-register
// hold/bubble vectors and a PC redirect. A watchdog on bus waits forces a full
// flush to TRAP_PC when the bus never acknowledges.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] TRAP_PC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        ex_busy_req_i,
  input  logic        ex_done_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        pc_load_o,
  output logic [31:0] new_pc_o,
  output logic        mem_err_o,
  output logic [1:0]  state_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StExWait  = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        mem_wait;
  logic        dispatch;
  logic        allow_mem;
  logic        allow_ex;
  logic [4:0]  stall;
  logic [4:0]  flush;
  logic        pc_load;
  logic [31:0] new_pc;
  logic        mem_err;

  assign mem_wait = mem_req_i & ~mem_ack_i;

  // State and watchdog counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; release cycles reuse the IDLE priority chain.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 5'b00000;
    flush     = 5'b00000;
    pc_load   = 1'b0;
    new_pc    = 32'h0;
    mem_err   = 1'b0;
    dispatch  = 1'b0;
    allow_mem = 1'b0;
    allow_ex  = 1'b0;

    unique case (state_q)
      StIdle: begin
        dispatch  = 1'b1;
        allow_mem = 1'b1;
        allow_ex  = 1'b1;
      end
      StMemWait: begin
        if (mem_ack_i) begin
          // Ack wins even in the timeout cycle.
          dispatch = 1'b1;
          allow_ex = 1'b1;
        end else if (cnt_q < CntMax) begin
          stall = 5'b01111;
          flush = 5'b10000;
          cnt_d = cnt_q + CntOne;
        end else begin
          stall   = 5'b01111;
          flush   = 5'b10000;
          mem_err = 1'b1;
          cnt_d   = '0;
          state_d = StFlush;
        end
      end
      StExWait: begin
        if (ex_done_i) begin
          dispatch  = 1'b1;
          allow_mem = 1'b1;
        end else if (mem_wait) begin
          // Watchdog intentionally idle here; EX is the longer stall.
          stall = 5'b01111;
          flush = 5'b10000;
        end else begin
          stall = 5'b00111;
          flush = 5'b01000;
        end
      end
      StFlush: begin
        flush   = 5'b11111;
        pc_load = 1'b1;
        new_pc  = TRAP_PC;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (dispatch) begin
      state_d = StIdle;
      cnt_d   = '0;
      if (allow_mem && mem_wait) begin
        stall   = 5'b01111;
        flush   = 5'b10000;
        cnt_d   = CntOne;
        state_d = StMemWait;
      end else if (allow_ex && ex_busy_req_i) begin
        stall   = 5'b00111;
        flush   = 5'b01000;
        state_d = StExWait;
      end else if (ex_branch_flag_i) begin
        flush   = 5'b00110;
        pc_load = 1'b1;
        new_pc  = ex_branch_addr_i;
      end else if (stallreq_id_i) begin
        stall = 5'b00011;
        flush = 5'b00100;
      end
    end
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    stall_o   = rst ? 5'b00000 : stall;
    flush_o   = rst ? 5'b00000 : flush;
    pc_load_o = rst ? 1'b0 : pc_load;
    new_pc_o  = rst ? 32'h0 : new_pc;
    mem_err_o = rst ? 1'b0 : mem_err;
    state_o   = rst ? 2'd0 : state_q;
  end

endmodule
